writeback_sequencer: RTL and testbench

//  Sequences retirement of one execute-stage result per transaction to its destination.

---
 rtl/writeback_sequencer.sv | 125 ++++++++++++
 tb/tb_writeback_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_sequencer.sv
// Retires one execute-stage result per transaction to the register file, data memory or PC.
// Owns destination routing, per-destination strobes and the timed memory-store handshake.
module writeback_sequencer #(
    parameter int WIDTH       = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int ZERO_REG    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [WIDTH-1:0]  in_addr,
    output logic [1:0]        sel,
    output logic [WIDTH-1:0]  dout,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic              mem_req,
    output logic [WIDTH-1:0]  mem_addr,
    input  logic              mem_ack,
    output logic              pc_load,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REG,
        S_MEM,
        S_PC
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [WIDTH-1:0]  r_dout;
    logic              r_reg_we;
    logic [REG_AW-1:0] r_reg_waddr;
    logic              r_mem_req;
    logic [WIDTH-1:0]  r_mem_addr;
    logic              r_pc_load;
    logic              r_err;
    logic [CW-1:0]     r_cnt;

    logic w_accept;
    logic w_zero_suppress;
    logic w_cnt_last;
    logic w_timeout;
    logic w_done;

    assign w_accept        = in_valid && (r_state == S_IDLE);
    assign w_zero_suppress = (ZERO_REG != 0) && (in_rd == '0);
    assign w_cnt_last      = (r_cnt == CW'(MEM_TIMEOUT - 1));
    // Ack takes priority over the timeout when both land in the same cycle.
    assign w_timeout       = (r_state == S_MEM) && !mem_ack && w_cnt_last;
    assign w_done          = (r_state == S_REG) || (r_state == S_PC) ||
                             ((r_state == S_MEM) && (mem_ack || w_cnt_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 2'b00;
            r_dout      <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_pc_load   <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_reg_we  <= 1'b0;
            r_pc_load <= 1'b0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_dout <= in_data;
                if (in_sel[0]) begin
                    r_state     <= S_REG;
                    r_sel       <= 2'b01;
                    r_reg_waddr <= in_rd;
                    r_reg_we    <= !w_zero_suppress;
                end else if (in_sel[1]) begin
                    r_state    <= S_MEM;
                    r_sel      <= 2'b10;
                    r_mem_addr <= in_addr;
                    r_mem_req  <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_state   <= S_PC;
                    r_sel     <= 2'b00;
                    r_pc_load <= 1'b1;
                end
            end else if (w_done) begin
                // Return to an inert router: select, data and addresses all zero.
                r_state     <= S_IDLE;
                r_sel       <= 2'b00;
                r_dout      <= '0;
                r_reg_waddr <= '0;
                r_mem_req   <= 1'b0;
                r_mem_addr  <= '0;
                r_cnt       <= '0;
            end else if (r_state == S_MEM) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign sel       = r_sel;
    assign dout      = r_dout;
    assign reg_we    = r_reg_we;
    assign reg_waddr = r_reg_waddr;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign pc_load   = r_pc_load;
    assign err       = r_err;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboard bench for writeback_sequencer: register, store, timeout, PC and reset scenarios.
module tb_writeback_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic [31:0] in_addr;
    logic [1:0]  sel;
    logic [31:0] dout;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        pc_load;
    logic        busy;
    logic        err;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    writeback_sequencer #(
        .WIDTH(32), .REG_AW(5), .MEM_TIMEOUT(TO), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .in_rd(in_rd), .in_addr(in_addr),
        .sel(sel), .dout(dout), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .pc_load(pc_load), .busy(busy), .err(err)
    );

    function automatic exp_t mk_exp(input logic [1:0] s, input logic [31:0] d,
                                    input logic [4:0] rd, input logic [31:0] a);
        exp_t e;
        e.sel  = s[0] ? 2'b01 : s;
        e.data = d;
        e.rd   = rd;
        e.addr = a;
        return e;
    endfunction

    // Waits for in_ready, presents one transaction for one edge; returns #1 after the accept edge.
    task automatic send(input logic [1:0] s, input logic [31:0] d,
                        input logic [4:0] rd, input logic [31:0] a);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%b required 1 after %0d cycles", in_ready, n);
        end
        sbq.push_back(mk_exp(s, d, rd, a));
        @(negedge clk);
        in_valid = 1'b1; in_sel = s; in_data = d; in_rd = rd; in_addr = a;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_addr = $urandom; in_rd = 5'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0;
        in_rd = '0; in_addr = '0; mem_ack = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, busy, reg_we, mem_req, pc_load, err, sel} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b required 10000000",
                     {in_ready, busy, reg_we, mem_req, pc_load, err, sel});
        end
        n_cmp++;
        if ({dout, mem_addr, reg_waddr} !== 69'd0) begin
            n_bad++;
            $display("FAIL reset_data: dout=%h mem_addr=%h reg_waddr=%0d required 0",
                     dout, mem_addr, reg_waddr);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reg_write;
        exp_t e;
        send(2'b01, 32'hDEADBEEF, 5'd5, 32'h0);
        e = sbq.pop_front();
        n_cmp++;
        if ({reg_we, pc_load, mem_req, busy, in_ready, sel} !== {5'b10010, e.sel}) begin
            n_bad++;
            $display("FAIL reg_ctl: got %b required %b",
                     {reg_we, pc_load, mem_req, busy, in_ready, sel}, {5'b10010, e.sel});
        end
        n_cmp++;
        if ({reg_waddr, dout} !== {e.rd, e.data}) begin
            n_bad++;
            $display("FAIL reg_data: waddr=%0d dout=%h required %0d %h", reg_waddr, dout, e.rd, e.data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({reg_we, busy, in_ready, sel, dout} !== {3'b001, 2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL reg_done: we=%b busy=%b rdy=%b sel=%b dout=%h required 0 0 1 00 0",
                     reg_we, busy, in_ready, sel, dout);
        end
    endtask

    task automatic test_zero_reg;
        exp_t e;
        send(2'b11, 32'hCAFEF00D, 5'd0, 32'h0);
        e = sbq.pop_front();
        n_cmp++;
        if ({reg_we, busy, in_ready, sel, dout} !== {3'b010, e.sel, e.data}) begin
            n_bad++;
            $display("FAIL zero_reg: we=%b busy=%b rdy=%b sel=%b dout=%h required 0 1 0 %b %h",
                     reg_we, busy, in_ready, sel, dout, e.sel, e.data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({reg_we, busy, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL zero_reg_done: we/busy/rdy=%b required 001", {reg_we, busy, in_ready});
        end
    endtask

    // Producer holds in_valid across two transactions; second is taken only once IDLE again.
    task automatic test_back_to_back;
        exp_t e;
        sbq.push_back(mk_exp(2'b01, 32'h11111111, 5'd7, 32'h0));
        sbq.push_back(mk_exp(2'b01, 32'h22222222, 5'd9, 32'h0));
        @(negedge clk);
        in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h11111111; in_rd = 5'd7;
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_cmp++;
        if ({reg_we, reg_waddr, dout} !== {1'b1, e.rd, e.data}) begin
            n_bad++;
            $display("FAIL b2b_first: we=%b waddr=%0d dout=%h required 1 %0d %h",
                     reg_we, reg_waddr, dout, e.rd, e.data);
        end
        in_data = 32'h22222222; in_rd = 5'd9;
        @(posedge clk); #1;
        n_cmp++;
        if ({reg_we, busy, in_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL b2b_gap: we/busy/rdy=%b required 001", {reg_we, busy, in_ready});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sbq.pop_front();
        n_cmp++;
        if ({reg_we, reg_waddr, dout} !== {1'b1, e.rd, e.data}) begin
            n_bad++;
            $display("FAIL b2b_second: we=%b waddr=%0d dout=%h required 1 %0d %h",
                     reg_we, reg_waddr, dout, e.rd, e.data);
        end
        @(posedge clk); #1;
    endtask

    // n_ack < 0 means never acknowledge; the store must then time out after TO cycles.
    task automatic test_store(input int n_ack, input logic exp_err, input logic [31:0] a,
                              input logic [31:0] d);
        exp_t e;
        int   hi;
        int   exp_hi;
        send(2'b10, d, 5'd0, a);
        e = sbq.pop_front();
        hi = 0;
        exp_hi = (n_ack < 0) ? TO : n_ack + 1;
        for (int k = 0; k < 20; k++) begin
            if (mem_req !== 1'b1) break;
            hi++;
            n_cmp++;
            if ({sel, mem_addr, dout, reg_we, pc_load} !== {e.sel, e.addr, e.data, 2'b00}) begin
                n_bad++;
                $display("FAIL store_hold: cyc=%0d sel=%b addr=%h dout=%h we=%b pc=%b required %b %h %h 0 0",
                         k, sel, mem_addr, dout, reg_we, pc_load, e.sel, e.addr, e.data);
            end
            if (k == n_ack) mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        n_cmp++;
        if (hi != exp_hi) begin
            n_bad++;
            $display("FAIL store_len: mem_req high %0d cycles required %0d", hi, exp_hi);
        end
        n_cmp++;
        if ({mem_req, in_ready, busy, err, sel, dout} !== {3'b010, exp_err, 2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL store_done: req=%b rdy=%b busy=%b err=%b sel=%b dout=%h required 0 1 0 %b 00 0",
                     mem_req, in_ready, busy, err, sel, dout, exp_err);
        end
    endtask

    task automatic test_ack_idle;
        mem_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({mem_req, busy, in_ready, reg_we, pc_load} !== 5'b00100) begin
                n_bad++;
                $display("FAIL ack_idle: req/busy/rdy/we/pc=%b required 00100",
                         {mem_req, busy, in_ready, reg_we, pc_load});
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_pc(input logic exp_err);
        exp_t e;
        send(2'b00, 32'h00400080, 5'd0, 32'h0);
        e = sbq.pop_front();
        n_cmp++;
        if ({pc_load, reg_we, mem_req, err, sel, dout} !== {3'b100, exp_err, e.sel, e.data}) begin
            n_bad++;
            $display("FAIL pc_load: pc=%b we=%b req=%b err=%b sel=%b dout=%h required 1 0 0 %b %b %h",
                     pc_load, reg_we, mem_req, err, sel, dout, exp_err, e.sel, e.data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({pc_load, in_ready, err} !== {2'b01, exp_err}) begin
            n_bad++;
            $display("FAIL pc_done: pc/rdy/err=%b required 01%b", {pc_load, in_ready, err}, exp_err);
        end
    endtask

    task automatic test_reset_mid_mem;
        exp_t e;
        send(2'b10, 32'h5555AAAA, 5'd0, 32'h200);
        e = sbq.pop_front();
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_req, busy, mem_addr} !== {2'b11, e.addr}) begin
            n_bad++;
            $display("FAIL rst_pre: req=%b busy=%b addr=%h required 1 1 %h", mem_req, busy, mem_addr, e.addr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, in_ready, busy, err, sel, dout, mem_addr} !== {4'b0100, 2'b00, 64'h0}) begin
            n_bad++;
            $display("FAIL rst_async: req=%b rdy=%b busy=%b err=%b sel=%b dout=%h addr=%h required 0 1 0 0 00 0 0",
                     mem_req, in_ready, busy, err, sel, dout, mem_addr);
        end
        @(negedge clk); rst = 1'b0;
        send(2'b01, 32'h0BADF00D, 5'd31, 32'h0);
        e = sbq.pop_front();
        n_cmp++;
        if ({reg_we, reg_waddr, dout} !== {1'b1, e.rd, e.data}) begin
            n_bad++;
            $display("FAIL rst_recover: we=%b waddr=%0d dout=%h required 1 %0d %h",
                     reg_we, reg_waddr, dout, e.rd, e.data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_zero_reg();
        test_back_to_back();
        test_store(2, 1'b0, 32'h100, 32'h1234);
        test_store(0, 1'b0, 32'h104, 32'hA5A5A5A5);
        test_store(TO - 1, 1'b0, 32'h108, 32'h0F0F0F0F);
        test_ack_idle();
        test_store(-1, 1'b1, 32'h10C, 32'h77778888);
        test_pc(1'b1);
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
